// File: rtl/vga_gfx_pixel_gen.sv
// Pixel stage for the 1024x768 VGA timing chain: 32x16-cell 1bpp bitmap,
// 2-colour palette and a blinking cursor cell. Every output lags its inputs
// by exactly two pixel clocks so rgb stays aligned with the delayed syncs.
module vga_gfx_pixel_gen #(
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] x,
  input  logic [4:0]  y_hi,
  input  logic [5:0]  y_lo,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [5:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_irq,
  output logic [7:0]  frame_count
);

  localparam logic [4:0] AddrPalette = 5'd16;
  localparam logic [4:0] AddrCursor  = 5'd17;

  // CPU-visible state
  logic [31:0] bitmap_q [16];
  logic [5:0]  bg_q, fg_q;
  logic [4:0]  cur_col_q;
  logic [3:0]  cur_row_q;
  logic        cur_en_q;

  // Stage 1 registers
  logic        s1_cell_q, s1_blank_q, s1_hsync_q, s1_vsync_q;

  // Stage 2 / frame registers (drive outputs directly)
  logic [5:0]  rgb_q;
  logic        hsync_q, vsync_q, frame_irq_q;
  logic [7:0]  frame_count_q;

  logic [31:0] row_bits;
  logic        cursor_hit;
  logic        cell_d;
  logic        vsync_fall;

  // y_lo is part of the timing-gen bus but cells are a whole band tall; the
  // top address bits only matter while blanked, where the lookup is ignored.
  logic unused_bits;
  assign unused_bits = ^{y_lo, y_hi[4], x[10]};

  // Stage-1 cell fetch with cursor inversion during the blink-on phase
  always_comb begin
    row_bits   = bitmap_q[y_hi[3:0]];
    cursor_hit = cur_en_q && (y_hi[3:0] == cur_row_q) && (x[9:5] == cur_col_q) &&
                 frame_count_q[BLINK_BIT];
    cell_d     = row_bits[x[9:5]] ^ cursor_hit;
  end

  // Register file writes; pixels fetched in the same cycle see the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bitmap_q[i] <= '0;
      bg_q      <= 6'h00;
      fg_q      <= 6'h3F;
      cur_col_q <= '0;
      cur_row_q <= '0;
      cur_en_q  <= 1'b0;
    end else if (wr_en) begin
      if (!wr_addr[4]) begin
        bitmap_q[wr_addr[3:0]] <= wr_data;
      end else if (wr_addr == AddrPalette) begin
        bg_q <= wr_data[5:0];
        fg_q <= wr_data[13:8];
      end else if (wr_addr == AddrCursor) begin
        cur_col_q <= wr_data[4:0];
        cur_row_q <= wr_data[11:8];
        cur_en_q  <= wr_data[16];
      end
    end
  end

  // Two-stage pixel pipeline; reset flushes in-flight pixels to blank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_cell_q  <= 1'b0;
      s1_blank_q <= 1'b1;
      s1_hsync_q <= 1'b1;
      s1_vsync_q <= 1'b1;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      s1_cell_q  <= cell_d;
      s1_blank_q <= blank_in;
      s1_hsync_q <= hsync_in;
      s1_vsync_q <= vsync_in;
      rgb_q      <= s1_blank_q ? 6'h00 : (s1_cell_q ? fg_q : bg_q);
      hsync_q    <= s1_hsync_q;
      vsync_q    <= s1_vsync_q;
    end
  end

  // vsync_out is about to fall on this edge when it is high and stage 1 is low
  assign vsync_fall = vsync_q & ~s1_vsync_q;

  // Frame pulse and counter update on the same edge that drops vsync_out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_irq_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_irq_q <= vsync_fall;
      if (vsync_fall) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_irq   = frame_irq_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_gfx_pixel_gen.sv
// Directed bench for vga_gfx_pixel_gen: one task per scenario, inline checks.
module tb_vga_gfx_pixel_gen;

  logic        clk;
  logic        rst_n;
  logic [10:0] x;
  logic [4:0]  y_hi;
  logic [5:0]  y_lo;
  logic        hsync_in, vsync_in, blank_in;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  rgb;
  logic        hsync_out, vsync_out, frame_irq;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  vga_gfx_pixel_gen #(.BLINK_BIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y_hi       (y_hi),
    .y_lo       (y_lo),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_irq  (frame_irq),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Hold one active pixel for two clocks and return what came out
  task automatic get_pix(input int px, input int py, output logic [5:0] r);
    x = 11'(px); y_hi = 5'(py); y_lo = 6'd0; blank_in = 1'b0;
    step();
    step();
    r = rgb;
  endtask

  // n vsync pulses during blanking, checking irq alignment every cycle
  task automatic vsync_pulses(input int n, inout int irq_cnt);
    logic prev_vs;
    logic fell;
    blank_in = 1'b1; hsync_in = 1'b1; x = 11'd1100; y_hi = 5'd16;
    prev_vs = vsync_out;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 6; c++) begin
        vsync_in = (c < 3) ? 1'b0 : 1'b1;
        step();
        fell = prev_vs && !vsync_out;
        checks++;
        if (frame_irq !== fell) begin
          errors++;
          $display("FAIL irq_align pulse %0d cyc %0d: got irq=%b want %b", p, c, frame_irq, fell);
        end
        if (frame_irq === 1'b1) irq_cnt++;
        prev_vs = vsync_out;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    x = '0; y_hi = '0; y_lo = '0; hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    apply_reset();
    checks++;
    if (rgb !== 6'h00 || hsync_out !== 1'b1 || vsync_out !== 1'b1 || frame_irq !== 1'b0 ||
        frame_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got rgb=%h hs=%b vs=%b irq=%b fc=%0d want 00 1 1 0 0",
               rgb, hsync_out, vsync_out, frame_irq, frame_count);
    end
  endtask

  // Full line with empty bitmap: black everywhere, hsync delayed by two
  task automatic test_blank_line();
    logic hs_prev;
    int   bad_rgb;
    int   bad_hs;
    hs_prev = 1'b1; bad_rgb = 0; bad_hs = 0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < 1344; i++) begin
      x = 11'(i); y_hi = 5'd0; y_lo = 6'd5;
      blank_in = (i >= 1024);
      hsync_in = !(i >= 1048 && i < 1184);
      step();
      if (rgb !== 6'h00) bad_rgb++;
      if (hsync_out !== hs_prev) bad_hs++;
      hs_prev = hsync_in;
    end
    checks++;
    if (bad_rgb != 0) begin
      errors++;
      $display("FAIL empty_line_rgb: %0d nonzero pixels, want 0", bad_rgb);
    end
    checks++;
    if (bad_hs != 0) begin
      errors++;
      $display("FAIL hsync_delay: %0d misaligned cycles, want 0", bad_hs);
    end
    hsync_in = 1'b1;
  endtask

  // Row 3 leftmost cell lit, palette fg=3 bg=0, streamed pixels
  task automatic test_bitmap_row();
    logic [5:0] exp;
    int         bad;
    bad = 0;
    write_reg(5'd3, 32'h0000_0001);
    write_reg(5'd16, 32'h0000_0300);
    for (int i = 0; i <= 42; i++) begin
      if (i <= 40) begin
        x = 11'(i); y_hi = 5'd3; blank_in = 1'b0;
      end else begin
        x = 11'd1030; blank_in = 1'b1;
      end
      step();
      if (i >= 2) begin
        exp = ((i - 1) <= 31) ? 6'h03 : 6'h00;
        if (rgb !== exp) begin
          bad++;
          $display("FAIL row3_pixel x=%0d: got %h want %h", i - 1, rgb, exp);
        end
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  // Blanking overrides the bitmap, even where the lookup would hit
  task automatic test_blanking();
    x = 11'd0; y_hi = 5'd3; blank_in = 1'b1;
    step();
    step();
    checks++;
    if (rgb !== 6'h00) begin
      errors++;
      $display("FAIL blank_lit_cell: got %h want 00", rgb);
    end
    y_hi = 5'd16;
    step();
    step();
    checks++;
    if (rgb !== 6'h00) begin
      errors++;
      $display("FAIL blank_y16: got %h want 00", rgb);
    end
  endtask

  // Cursor at col 5 row 2 toggles with frame_count bit 4
  task automatic test_cursor();
    logic [5:0] r;
    int         irqs;
    irqs = 0;
    write_reg(5'd17, 32'h0001_0205);
    get_pix(5 * 32 + 3, 2, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL cursor_phase0: got %h want 00", r);
    end
    vsync_pulses(16, irqs);
    checks++;
    if (frame_count !== 8'd16) begin
      errors++;
      $display("FAIL fc_16: got %0d want 16", frame_count);
    end
    get_pix(5 * 32, 2, r);
    checks++;
    if (r !== 6'h03) begin
      errors++;
      $display("FAIL cursor_on_left: got %h want 03", r);
    end
    get_pix(5 * 32 + 31, 2, r);
    checks++;
    if (r !== 6'h03) begin
      errors++;
      $display("FAIL cursor_on_right: got %h want 03", r);
    end
    get_pix(6 * 32, 2, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL cursor_next_col: got %h want 00", r);
    end
    get_pix(5 * 32, 3, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL cursor_other_row: got %h want 00", r);
    end
    vsync_pulses(16, irqs);
    get_pix(5 * 32 + 10, 2, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL cursor_phase_off: got %h want 00", r);
    end
  endtask

  // 256 frames: one irq per frame and the counter wraps to its start
  task automatic test_frame_wrap();
    int irqs;
    irqs = 0;
    apply_reset();
    vsync_pulses(255, irqs);
    checks++;
    if (frame_count !== 8'd255) begin
      errors++;
      $display("FAIL fc_255: got %0d want 255", frame_count);
    end
    vsync_pulses(1, irqs);
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap: got %0d want 0", frame_count);
    end
    checks++;
    if (irqs != 256) begin
      errors++;
      $display("FAIL irq_count: got %0d want 256", irqs);
    end
  endtask

  // One-cycle reset mid-line flushes fg pixels and restores the palette
  task automatic test_midline_reset();
    logic [5:0] r;
    write_reg(5'd16, 32'h0000_0300);
    write_reg(5'd0, 32'hFFFF_FFFF);
    vsync_in = 1'b1; hsync_in = 1'b0; y_hi = 5'd0; blank_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = 11'(i);
      step();
    end
    checks++;
    if (rgb !== 6'h03 || hsync_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_fg: got rgb=%h hs=%b want 03 0", rgb, hsync_out);
    end
    rst_n = 1'b0;
    x = 11'd4;
    step();
    rst_n = 1'b1;
    checks++;
    if (rgb !== 6'h00 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: got rgb=%h hs=%b vs=%b want 00 1 1", rgb, hsync_out, vsync_out);
    end
    x = 11'd5;
    step();
    checks++;
    if (rgb !== 6'h00 || hsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush_s1: got rgb=%h hs=%b want 00 1", rgb, hsync_out);
    end
    hsync_in = 1'b1;
    get_pix(0, 0, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL bitmap_cleared: got %h want 00", r);
    end
    write_reg(5'd0, 32'h0000_0001);
    get_pix(0, 0, r);
    checks++;
    if (r !== 6'h3F) begin
      errors++;
      $display("FAIL fg_default: got %h want 3f", r);
    end
    get_pix(32, 0, r);
    checks++;
    if (r !== 6'h00) begin
      errors++;
      $display("FAIL bg_default: got %h want 00", r);
    end
  endtask

  initial begin
    test_reset();
    test_blank_line();
    test_bitmap_row();
    test_blanking();
    test_cursor();
    test_frame_wrap();
    test_midline_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
